// File: rtl/p4_hdr_programmer.sv
// AXI4-Lite master that writes the P4 header fields into the register block
// as 9 sequential word writes, optionally reading every word back to compare.
module p4_hdr_programmer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        axil_aclk,
  input  logic        axil_aresetn,
  input  logic        start,
  input  logic [47:0] smac,
  input  logic [47:0] dmac,
  input  logic [31:0] sip,
  input  logic [31:0] dip,
  input  logic [15:0] sport,
  input  logic [15:0] dport,
  input  logic [15:0] ipsum,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  err_index,
  output logic        m_axil_awvalid,
  output logic [31:0] m_axil_awaddr,
  input  logic        m_axil_awready,
  output logic        m_axil_wvalid,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  input  logic        m_axil_wready,
  input  logic        m_axil_bvalid,
  input  logic [1:0]  m_axil_bresp,
  output logic        m_axil_bready,
  output logic        m_axil_arvalid,
  output logic [31:0] m_axil_araddr,
  input  logic        m_axil_arready,
  input  logic        m_axil_rvalid,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  output logic        m_axil_rready
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  LAST_IDX = 4'd8;
  localparam logic [1:0]  E_RESP   = 2'b01;
  localparam logic [1:0]  E_DATA   = 2'b10;
  localparam logic [1:0]  E_TMO    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FIN
  } state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_aw_done;
  logic          r_w_done;
  logic [47:0]   r_smac;
  logic [47:0]   r_dmac;
  logic [31:0]   r_sip;
  logic [31:0]   r_dip;
  logic [15:0]   r_sport;
  logic [15:0]   r_dport;
  logic [15:0]   r_ipsum;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_aw_fin;
  logic          w_w_fin;
  logic          w_b_hs;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_active;
  logic          w_exit;
  logic          w_tmo_hit;
  logic          w_last;
  logic [3:0]    w_next_idx;
  logic [31:0]   w_exp;

  // Register word for a given index, built from whichever field set is passed in.
  function automatic logic [31:0] f_word(
    input logic [3:0]  idx,
    input logic [47:0] smac_v,
    input logic [47:0] dmac_v,
    input logic [31:0] sip_v,
    input logic [31:0] dip_v,
    input logic [15:0] sport_v,
    input logic [15:0] dport_v,
    input logic [15:0] ipsum_v
  );
    case (idx)
      4'd0:    f_word = smac_v[31:0];
      4'd1:    f_word = {16'h0000, smac_v[47:32]};
      4'd2:    f_word = dmac_v[31:0];
      4'd3:    f_word = {16'h0000, dmac_v[47:32]};
      4'd4:    f_word = sip_v;
      4'd5:    f_word = dip_v;
      4'd6:    f_word = {16'h0000, sport_v};
      4'd7:    f_word = {16'h0000, dport_v};
      4'd8:    f_word = {16'h0000, ipsum_v};
      default: f_word = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] f_addr(input logic [3:0] idx);
    f_addr = BASE_ADDR + {26'd0, idx, 2'b00};
  endfunction

  assign m_axil_wstrb = 4'hF;

  assign w_aw_hs    = m_axil_awvalid & m_axil_awready;
  assign w_w_hs     = m_axil_wvalid & m_axil_wready;
  assign w_aw_fin   = r_aw_done | w_aw_hs;
  assign w_w_fin    = r_w_done | w_w_hs;
  assign w_b_hs     = m_axil_bvalid & m_axil_bready;
  assign w_ar_hs    = m_axil_arvalid & m_axil_arready;
  assign w_r_hs     = m_axil_rvalid & m_axil_rready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_next_idx = r_idx + 4'd1;
  assign w_exp      = f_word(r_idx, r_smac, r_dmac, r_sip, r_dip, r_sport, r_dport, r_ipsum);

  // A state is left this cycle; such cycles never count as a timeout.
  always_comb begin
    w_active = 1'b0;
    w_exit   = 1'b0;
    case (r_state)
      S_WR_REQ:  begin w_active = 1'b1; w_exit = w_aw_fin & w_w_fin; end
      S_WR_RESP: begin w_active = 1'b1; w_exit = w_b_hs;             end
      S_RD_REQ:  begin w_active = 1'b1; w_exit = w_ar_hs;            end
      S_RD_RESP: begin w_active = 1'b1; w_exit = w_r_hs;             end
      default:   begin w_active = 1'b0; w_exit = 1'b0;               end
    endcase
  end

  assign w_tmo_hit = w_active & ~w_exit & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_state        <= S_IDLE;
      r_idx          <= 4'd0;
      r_tmo          <= '0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_smac         <= 48'd0;
      r_dmac         <= 48'd0;
      r_sip          <= 32'd0;
      r_dip          <= 32'd0;
      r_sport        <= 16'd0;
      r_dport        <= 16'd0;
      r_ipsum        <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'b00;
      err_index      <= 4'd0;
      m_axil_awvalid <= 1'b0;
      m_axil_awaddr  <= 32'd0;
      m_axil_wvalid  <= 1'b0;
      m_axil_wdata   <= 32'd0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr  <= 32'd0;
      m_axil_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_active) r_tmo <= r_tmo + TW'(1);

      if (w_tmo_hit) begin
        // Recovery only: drop every handshake signal regardless of slave state.
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid  <= 1'b0;
        m_axil_bready  <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_rready  <= 1'b0;
        error          <= 1'b1;
        err_code       <= E_TMO;
        err_index      <= r_idx;
        busy           <= 1'b0;
        done           <= 1'b1;
        r_state        <= S_FIN;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_smac         <= smac;
              r_dmac         <= dmac;
              r_sip          <= sip;
              r_dip          <= dip;
              r_sport        <= sport;
              r_dport        <= dport;
              r_ipsum        <= ipsum;
              error          <= 1'b0;
              err_code       <= 2'b00;
              err_index      <= 4'd0;
              r_idx          <= 4'd0;
              busy           <= 1'b1;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              m_axil_awaddr  <= f_addr(4'd0);
              m_axil_wdata   <= f_word(4'd0, smac, dmac, sip, dip, sport, dport, ipsum);
              r_aw_done      <= 1'b0;
              r_w_done       <= 1'b0;
              r_tmo          <= '0;
              r_state        <= S_WR_REQ;
            end
          end

          S_WR_REQ: begin
            if (w_aw_hs) begin
              m_axil_awvalid <= 1'b0;
              r_aw_done      <= 1'b1;
            end
            if (w_w_hs) begin
              m_axil_wvalid <= 1'b0;
              r_w_done      <= 1'b1;
            end
            if (w_aw_fin && w_w_fin) begin
              m_axil_bready <= 1'b1;
              r_tmo         <= '0;
              r_state       <= S_WR_RESP;
            end
          end

          S_WR_RESP: begin
            if (w_b_hs) begin
              m_axil_bready <= 1'b0;
              r_tmo         <= '0;
              if (m_axil_bresp != 2'b00) begin
                error     <= 1'b1;
                err_code  <= E_RESP;
                err_index <= r_idx;
                busy      <= 1'b0;
                done      <= 1'b1;
                r_state   <= S_FIN;
              end else if (w_last) begin
                if (VERIFY) begin
                  r_idx          <= 4'd0;
                  m_axil_arvalid <= 1'b1;
                  m_axil_araddr  <= f_addr(4'd0);
                  r_state        <= S_RD_REQ;
                end else begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_FIN;
                end
              end else begin
                r_idx          <= w_next_idx;
                m_axil_awvalid <= 1'b1;
                m_axil_wvalid  <= 1'b1;
                m_axil_awaddr  <= f_addr(w_next_idx);
                m_axil_wdata   <= f_word(w_next_idx, r_smac, r_dmac, r_sip, r_dip,
                                         r_sport, r_dport, r_ipsum);
                r_aw_done      <= 1'b0;
                r_w_done       <= 1'b0;
                r_state        <= S_WR_REQ;
              end
            end
          end

          S_RD_REQ: begin
            if (w_ar_hs) begin
              m_axil_arvalid <= 1'b0;
              m_axil_rready  <= 1'b1;
              r_tmo          <= '0;
              r_state        <= S_RD_RESP;
            end
          end

          S_RD_RESP: begin
            if (w_r_hs) begin
              m_axil_rready <= 1'b0;
              r_tmo         <= '0;
              if (m_axil_rresp != 2'b00 || m_axil_rdata != w_exp) begin
                error     <= 1'b1;
                err_code  <= (m_axil_rresp != 2'b00) ? E_RESP : E_DATA;
                err_index <= r_idx;
                busy      <= 1'b0;
                done      <= 1'b1;
                r_state   <= S_FIN;
              end else if (w_last) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_idx          <= w_next_idx;
                m_axil_arvalid <= 1'b1;
                m_axil_araddr  <= f_addr(w_next_idx);
                r_state        <= S_RD_REQ;
              end
            end
          end

          S_FIN:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
